// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Holds a small program of 10-bit words and steps an external processor
//   through it. Each step raises STEP for one cycle (ISSUE), then keeps STEP
//   low for GAP_CYC cycles (GAP). The word at PC is presented combinationally
//   on DATA_OUT. When the processor requests external data (EXT) the word is
//   consumed and PC advances. If EXT arrives after the last word has been
//   consumed, the block enters ERROR. Playback ends in FINISH once DONE has
//   been seen and the whole program has been consumed.
//
//   Optional feature, enabled by defining SEQ_STEP_WATCHDOG_EN:
//     a step watchdog counts consecutive steps that see DONE=0. The fourth
//     such step sends the sequencer to ERROR after its GAP. Without the
//     macro, no watchdog logic is built and stepping continues
//     indefinitely.

module instr_sequencer #(
  parameter int DEPTH   = 16,
  parameter int GAP_CYC = 2
) (
  input  logic                   CLK,
  input  logic                   RSTb,
  input  logic                   WR_EN,
  input  logic [9:0]             WR_DATA,
  input  logic                   LOAD_CLR,
  input  logic                   START,
  input  logic                   EXT,
  input  logic                   DONE,
  output logic [9:0]             DATA_OUT,
  output logic                   DATA_VALID,
  output logic                   STEP,
  output logic                   BUSY,
  output logic                   HALT,
  output logic                   ERR,
  output logic                   FULL,
  output logic [$clog2(DEPTH):0] PC,
  output logic [$clog2(DEPTH):0] COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  // The GAP counter runs from 0 to GAP_CYC-1.
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [PW-1:0] DEPTH_V  = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_GAP    = 3'd2,
    S_FINISH = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

  // State and datapath registers
  state_e          state_q, state_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic [PW-1:0]   count_q, count_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            done_q, done_d;

  // Registered status outputs
  logic            step_q, step_d;
  logic            busy_q, busy_d;
  logic            halt_q, halt_d;
  logic            err_q, err_d;
  logic            full_q, full_d;

  // Program storage. It is deliberately not reset.
  logic [9:0]      mem_q [DEPTH];

  // Decoded events
  logic            wr_ok_s;
  logic            start_ok_s;
  logic            ext_take_s;
  logic            underrun_s;
  logic            gap_end_s;
  logic            wd_trip_s;

  // Read-path results
  logic [9:0]      data_out_s;
  logic            data_valid_s;

  // Decode the qualified events for this cycle. LOAD_CLR blocks writes.
  always_comb begin
    wr_ok_s    = WR_EN && !LOAD_CLR && !full_q && (state_q == S_IDLE);
    start_ok_s = START && (count_q != PTR_ZERO) &&
                 ((state_q == S_IDLE) || (state_q == S_FINISH));
    ext_take_s = (state_q == S_ISSUE) && EXT && (pc_q < count_q);
    underrun_s = (state_q == S_ISSUE) && EXT && (pc_q == count_q);
    gap_end_s  = (state_q == S_GAP) && (gap_q == GAP_LAST);
  end

`ifdef SEQ_STEP_WATCHDOG_EN
  // Watchdog: counts consecutive steps that see DONE=0. The count
  // saturates at 4.
  logic [2:0] wd_q, wd_d;

  // Update the count of consecutive DONE-less steps.
  always_comb begin
    wd_d = wd_q;
    if (LOAD_CLR) begin
      wd_d = 3'd0;
    end else if (start_ok_s) begin
      wd_d = 3'd0;
    end else if (state_q == S_ISSUE) begin
      if (DONE) begin
        wd_d = 3'd0;
      end else if (wd_q != 3'd4) begin
        wd_d = wd_q + 3'd1;
      end else begin
        wd_d = wd_q;
      end
    end else begin
      wd_d = wd_q;
    end
  end

  // Watchdog count register.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      wd_q <= 3'd0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign wd_trip_s = (wd_q == 3'd4);
`else
  assign wd_trip_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. LOAD_CLR overrides every other input.
  always_comb begin
    state_d = state_q;
    if (LOAD_CLR) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_FINISH: begin
          if (start_ok_s) begin
            state_d = S_ISSUE;
          end else begin
            state_d = state_q;
          end
        end
        S_ISSUE: begin
          if (underrun_s) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          if (!gap_end_s) begin
            state_d = S_GAP;
          end else if (wd_trip_s) begin
            state_d = S_ERROR;
          end else if (done_q && (pc_q == count_q)) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_ISSUE;
          end
        end
        S_ERROR: begin
          state_d = S_ERROR;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // FSM outputs. These are decoded from the next state so that the status
  // flops line up with state_q.
  always_comb begin
    step_d = 1'b0;
    busy_d = 1'b0;
    halt_d = 1'b0;
    err_d  = 1'b0;
    case (state_d)
      S_IDLE: begin
        step_d = 1'b0;
      end
      S_ISSUE: begin
        step_d = 1'b1;
        busy_d = 1'b1;
      end
      S_GAP: begin
        busy_d = 1'b1;
      end
      S_FINISH: begin
        halt_d = 1'b1;
      end
      S_ERROR: begin
        err_d = 1'b1;
      end
      default: begin
        step_d = 1'b0;
      end
    endcase
    full_d = (count_d == DEPTH_V);
  end

  // Datapath next values: PC, COUNT, GAP timer, and the DONE sampled
  // during ISSUE.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    gap_d   = gap_q;
    done_d  = done_q;
    if (LOAD_CLR) begin
      pc_d    = PTR_ZERO;
      count_d = PTR_ZERO;
      gap_d   = {GW{1'b0}};
      done_d  = 1'b0;
    end else begin
      if (wr_ok_s) begin
        count_d = count_q + PTR_ONE;
      end else begin
        count_d = count_q;
      end

      if (start_ok_s) begin
        pc_d = PTR_ZERO;
      end else if (ext_take_s) begin
        pc_d = pc_q + PTR_ONE;
      end else begin
        pc_d = pc_q;
      end

      if (state_q == S_ISSUE) begin
        done_d = DONE;
        gap_d  = {GW{1'b0}};
      end else if ((state_q == S_GAP) && !gap_end_s) begin
        done_d = done_q;
        gap_d  = gap_q + GW'(1);
      end else begin
        done_d = done_q;
        gap_d  = gap_q;
      end
    end
  end

  // Datapath and status registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      pc_q    <= PTR_ZERO;
      count_q <= PTR_ZERO;
      gap_q   <= {GW{1'b0}};
      done_q  <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
      full_q  <= full_d;
    end
  end

  // Program memory write at the current tail.
  always_ff @(posedge CLK) begin
    if (wr_ok_s) begin
      mem_q[count_q[AW-1:0]] <= WR_DATA;
    end
  end

  // Combinational read of the word at PC. Output is zero past the tail.
  always_comb begin
    if (pc_q < count_q) begin
      data_out_s   = mem_q[pc_q[AW-1:0]];
      data_valid_s = 1'b1;
    end else begin
      data_out_s   = 10'h000;
      data_valid_s = 1'b0;
    end
  end

  assign DATA_OUT   = data_out_s;
  assign DATA_VALID = data_valid_s;
  assign STEP       = step_q;
  assign BUSY       = busy_q;
  assign HALT       = halt_q;
  assign ERR        = err_q;
  assign FULL       = full_q;
  assign PC         = pc_q;
  assign COUNT      = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer. Inputs are driven just after the
// falling edge and outputs are observed at the falling edge. The random
// scenario compares against a step-level reference model built from a word
// queue and integer counters.
module tb_instr_sequencer;

  localparam int DEPTH   = 16;
  localparam int GAP_CYC = 2;
  localparam int PW      = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RSTb;
  logic          WR_EN;
  logic [9:0]    WR_DATA;
  logic          LOAD_CLR;
  logic          START;
  logic          EXT;
  logic          DONE;
  logic [9:0]    DATA_OUT;
  logic          DATA_VALID;
  logic          STEP;
  logic          BUSY;
  logic          HALT;
  logic          ERR;
  logic          FULL;
  logic [PW-1:0] PC;
  logic [PW-1:0] COUNT;

  int total = 0;
  int bad   = 0;

  instr_sequencer #(.DEPTH(DEPTH), .GAP_CYC(GAP_CYC)) dut (
    .CLK(CLK), .RSTb(RSTb), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
    .LOAD_CLR(LOAD_CLR), .START(START), .EXT(EXT), .DONE(DONE),
    .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .STEP(STEP),
    .BUSY(BUSY), .HALT(HALT), .ERR(ERR), .FULL(FULL), .PC(PC), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_clear();
    LOAD_CLR = 1'b1;
    tick();
    LOAD_CLR = 1'b0;
  endtask

  task automatic write_word(input logic [9:0] w);
    WR_EN = 1'b1;
    WR_DATA = w;
    tick();
    WR_EN = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Waits (bounded) until STEP is high at a falling edge.
  task automatic wait_step(output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      if (STEP === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
      waited++;
    end
  endtask

  task automatic count_steps(input int ncyc, output int n);
    n = 0;
    repeat (ncyc) begin
      tick();
      if (STEP === 1'b1) n++;
    end
  endtask

  task automatic test_reset();
    int n;
    RSTb = 1'b0; WR_EN = 1'b0; WR_DATA = 10'h000; LOAD_CLR = 1'b0;
    START = 1'b0; EXT = 1'b0; DONE = 1'b0;
    #3;
    total++;
    if ({STEP, BUSY, HALT, ERR, FULL, DATA_VALID} !== 6'b0 || DATA_OUT !== 10'h000 ||
        PC !== PW'(0) || COUNT !== PW'(0)) begin
      bad++;
      $display("FAIL reset_outputs: flags=%b out=%h pc=%0d cnt=%0d, want all 0",
               {STEP, BUSY, HALT, ERR, FULL, DATA_VALID}, DATA_OUT, PC, COUNT);
    end
    repeat (2) tick();
    RSTb = 1'b1;
    pulse_start();
    count_steps(4, n);
    total++;
    if (n != 0 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL start_empty: steps=%0d busy=%b, want 0 0", n, BUSY);
    end
  endtask

  task automatic test_normal_run();
    bit ok; int w, n, nst;
    do_clear();
    write_word(10'h040);
    write_word(10'h005);
    total++;
    if (COUNT !== PW'(2) || DATA_OUT !== 10'h040 || DATA_VALID !== 1'b1) begin
      bad++;
      $display("FAIL load2: cnt=%0d out=%h v=%b, want 2 040 1", COUNT, DATA_OUT, DATA_VALID);
    end
    pulse_start();
    nst = 0;
    wait_step(ok, w); if (ok) nst++;
    total++;
    if (!ok || DATA_OUT !== 10'h040 || PC !== PW'(0) || BUSY !== 1'b1) begin
      bad++;
      $display("FAIL run_step1: ok=%b out=%h pc=%0d, want 1 040 0", ok, DATA_OUT, PC);
    end
    EXT = 1'b1; tick(); EXT = 1'b0;
    wait_step(ok, w); if (ok) nst++;
    total++;
    if (!ok || DATA_OUT !== 10'h005 || PC !== PW'(1)) begin
      bad++;
      $display("FAIL run_step2: ok=%b out=%h pc=%0d, want 1 005 1", ok, DATA_OUT, PC);
    end
    EXT = 1'b1; tick(); EXT = 1'b0;
    wait_step(ok, w); if (ok) nst++;
    total++;
    if (!ok || PC !== PW'(2) || DATA_VALID !== 1'b0) begin
      bad++;
      $display("FAIL run_step3: ok=%b pc=%0d v=%b, want 1 2 0", ok, PC, DATA_VALID);
    end
    DONE = 1'b1; tick(); DONE = 1'b0;
    count_steps(2 * GAP_CYC + 2, n);
    nst += n;
    total++;
    if (nst != 3 || HALT !== 1'b1 || BUSY !== 1'b0 || PC !== PW'(2)) begin
      bad++;
      $display("FAIL run_finish: steps=%0d halt=%b busy=%b pc=%0d, want 3 1 0 2",
               nst, HALT, BUSY, PC);
    end
    pulse_start();
    wait_step(ok, w);
    total++;
    if (!ok || PC !== PW'(0) || HALT !== 1'b0 || DATA_OUT !== 10'h040) begin
      bad++;
      $display("FAIL restart: ok=%b pc=%0d halt=%b out=%h, want 1 0 0 040", ok, PC, HALT, DATA_OUT);
    end
    do_clear();
  endtask

  task automatic test_underrun();
    bit ok; int w, n;
    do_clear();
    write_word(10'h2A5);
    pulse_start();
    wait_step(ok, w);
    EXT = 1'b1; tick(); EXT = 1'b0;
    wait_step(ok, w);
    total++;
    if (!ok || PC !== PW'(1)) begin
      bad++;
      $display("FAIL under_step2: ok=%b pc=%0d, want 1 1", ok, PC);
    end
    EXT = 1'b1; tick(); EXT = 1'b0;
    total++;
    if (ERR !== 1'b1 || PC !== PW'(1) || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL under_err: err=%b pc=%0d busy=%b, want 1 1 0", ERR, PC, BUSY);
    end
    pulse_start();
    write_word(10'h111);
    count_steps(8, n);
    total++;
    if (n != 0 || ERR !== 1'b1 || COUNT !== PW'(1)) begin
      bad++;
      $display("FAIL under_hold: steps=%0d err=%b cnt=%0d, want 0 1 1", n, ERR, COUNT);
    end
    do_clear();
    total++;
    if (ERR !== 1'b0 || COUNT !== PW'(0)) begin
      bad++;
      $display("FAIL under_clear: err=%b cnt=%0d, want 0 0", ERR, COUNT);
    end
  endtask

  task automatic test_overflow();
    bit ok; int w, n;
    logic [9:0] exp_w;
    do_clear();
    for (int i = 0; i < 17; i++) write_word(10'(i));
    total++;
    if (COUNT !== PW'(16) || FULL !== 1'b1) begin
      bad++;
      $display("FAIL ovf_count: cnt=%0d full=%b, want 16 1", COUNT, FULL);
    end
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      wait_step(ok, w);
      exp_w = 10'(i);
      total++;
      if (!ok || DATA_OUT !== exp_w || DATA_VALID !== 1'b1) begin
        bad++;
        $display("FAIL ovf_word%0d: ok=%b out=%h, want %h", i, ok, DATA_OUT, exp_w);
      end
      EXT = 1'b1; DONE = 1'b1; tick(); EXT = 1'b0; DONE = 1'b0;
    end
    count_steps(2 * GAP_CYC + 2, n);
    total++;
    if (n != 0 || HALT !== 1'b1 || PC !== PW'(16) || DATA_VALID !== 1'b0 || COUNT !== PW'(16)) begin
      bad++;
      $display("FAIL ovf_end: steps=%0d halt=%b pc=%0d v=%b, want 0 1 16 0", n, HALT, PC, DATA_VALID);
    end
    do_clear();
  endtask

  task automatic test_clr_priority();
    int n;
    do_clear();
    write_word(10'h001); write_word(10'h002); write_word(10'h003);
    total++;
    if (COUNT !== PW'(3)) begin
      bad++;
      $display("FAIL clr_pre: cnt=%0d, want 3", COUNT);
    end
    LOAD_CLR = 1'b1; WR_EN = 1'b1; WR_DATA = 10'h3FF;
    tick();
    LOAD_CLR = 1'b0; WR_EN = 1'b0;
    total++;
    if (COUNT !== PW'(0) || DATA_VALID !== 1'b0 || DATA_OUT !== 10'h000 || FULL !== 1'b0) begin
      bad++;
      $display("FAIL clr_vs_wr: cnt=%0d v=%b out=%h, want 0 0 000", COUNT, DATA_VALID, DATA_OUT);
    end
    write_word(10'h010); write_word(10'h020);
    LOAD_CLR = 1'b1; START = 1'b1;
    tick();
    LOAD_CLR = 1'b0; START = 1'b0;
    count_steps(4, n);
    total++;
    if (n != 0 || BUSY !== 1'b0 || COUNT !== PW'(0)) begin
      bad++;
      $display("FAIL clr_vs_start: steps=%0d busy=%b cnt=%0d, want 0 0 0", n, BUSY, COUNT);
    end
  endtask

  task automatic test_midrun_reset();
    bit ok; int w, n;
    do_clear();
    write_word(10'h0AA); write_word(10'h0BB);
    pulse_start();
    wait_step(ok, w);
    EXT = 1'b1; tick(); EXT = 1'b0;
    total++;
    if (PC !== PW'(1) || BUSY !== 1'b1 || STEP !== 1'b0) begin
      bad++;
      $display("FAIL rst_pre_gap: pc=%0d busy=%b step=%b, want 1 1 0", PC, BUSY, STEP);
    end
    RSTb = 1'b0;
    #1;
    total++;
    if ({STEP, BUSY, HALT, ERR, FULL, DATA_VALID} !== 6'b0 || DATA_OUT !== 10'h000 ||
        PC !== PW'(0) || COUNT !== PW'(0)) begin
      bad++;
      $display("FAIL rst_mid: flags=%b out=%h pc=%0d cnt=%0d, want all 0",
               {STEP, BUSY, HALT, ERR, FULL, DATA_VALID}, DATA_OUT, PC, COUNT);
    end
    repeat (2) tick();
    RSTb = 1'b1;
    count_steps(8, n);
    total++;
    if (n != 0 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL rst_release: steps=%0d busy=%b, want 0 0", n, BUSY);
    end
  endtask

  task automatic test_watchdog();
    bit ok; int w, n;
    do_clear();
    for (int i = 0; i < 4; i++) write_word(10'(i + 100));
    pulse_start();
    for (int s = 0; s < 4; s++) begin
      wait_step(ok, w);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL wd_step%0d: STEP missing", s);
      end
      tick();
    end
    count_steps(GAP_CYC + 4, n);
    total++;
`ifdef SEQ_STEP_WATCHDOG_EN
    if (n != 0 || ERR !== 1'b1 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL wd_trip: steps=%0d err=%b, want 0 1", n, ERR);
    end
`else
    if (n < 1 || ERR !== 1'b0) begin
      bad++;
      $display("FAIL wd_absent: steps=%0d err=%b, want >=1 0", n, ERR);
    end
`endif
    do_clear();
  endtask

  task automatic test_random();
    logic [9:0] prog[$];
    logic [9:0] w, exp_out;
    int nwr, m_pc, m_wd, waited;
    bit ok, ext, dn, ended;
    for (int it = 0; it < 10; it++) begin
      do_clear();
      prog.delete();
      nwr = $urandom_range(1, DEPTH + 2);
      for (int k = 0; k < nwr; k++) begin
        w = 10'($urandom);
        write_word(w);
        if (prog.size() < DEPTH) prog.push_back(w);
      end
      total++;
      if (COUNT !== PW'(prog.size()) || FULL !== ((prog.size() == DEPTH) ? 1'b1 : 1'b0)) begin
        bad++;
        $display("FAIL rnd_load: cnt=%0d full=%b, want %0d", COUNT, FULL, prog.size());
      end
      m_pc = 0; m_wd = 0; ended = 1'b0;
      pulse_start();
      for (int s = 0; s < 30 && !ended; s++) begin
        wait_step(ok, waited);
        total++;
        if (!ok) begin
          bad++;
          $display("FAIL rnd_step_timeout: it=%0d step=%0d", it, s);
          ended = 1'b1;
        end else begin
          exp_out = (m_pc < prog.size()) ? prog[m_pc] : 10'h000;
          if ((s > 0 && waited != GAP_CYC) || PC !== PW'(m_pc) || DATA_OUT !== exp_out ||
              DATA_VALID !== ((m_pc < prog.size()) ? 1'b1 : 1'b0) || BUSY !== 1'b1) begin
            bad++;
            $display("FAIL rnd_step: it=%0d s=%0d gap=%0d pc=%0d out=%h v=%b, want gap=%0d pc=%0d out=%h",
                     it, s, waited, PC, DATA_OUT, DATA_VALID, GAP_CYC, m_pc, exp_out);
          end
          ext = ($urandom_range(0, 9) < 7);
          dn  = ($urandom_range(0, 3) == 0);
          EXT = ext; DONE = dn;
          tick();
          EXT = 1'b0; DONE = 1'b0;
          if (ext && m_pc == prog.size()) begin
            total++;
            if (ERR !== 1'b1 || BUSY !== 1'b0) begin
              bad++;
              $display("FAIL rnd_underrun: err=%b busy=%b, want 1 0", ERR, BUSY);
            end
            ended = 1'b1;
          end else begin
            if (ext) m_pc++;
            m_wd = dn ? 0 : m_wd + 1;
            if (dn && m_pc == prog.size()) begin
              repeat (GAP_CYC) tick();
              total++;
              if (HALT !== 1'b1 || BUSY !== 1'b0 || STEP !== 1'b0 || PC !== PW'(m_pc)) begin
                bad++;
                $display("FAIL rnd_finish: halt=%b busy=%b pc=%0d, want 1 0 %0d", HALT, BUSY, PC, m_pc);
              end
              ended = 1'b1;
            end
`ifdef SEQ_STEP_WATCHDOG_EN
            else if (m_wd == 4) begin
              repeat (GAP_CYC) tick();
              total++;
              if (ERR !== 1'b1 || STEP !== 1'b0) begin
                bad++;
                $display("FAIL rnd_wd: err=%b step=%b, want 1 0", ERR, STEP);
              end
              ended = 1'b1;
            end
`endif
          end
        end
      end
    end
    do_clear();
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_underrun();
    test_overflow();
    test_clr_priority();
    test_midrun_reset();
    test_watchdog();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of 10-bit program words stored (power of 2, 2..64).
REQ-002 SHALL have parameter GAP_CYC, default 2, meaning the minimum number of cycles STEP stays low between pulses (>=1).
REQ-003 SHALL have port CLK  in  1  single clock, rising-edge.
REQ-004 SHALL have port RSTb  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port WR_EN  in  1  write WR_DATA at the program tail.
REQ-006 SHALL have port WR_DATA  in  10  program word (instruction or immediate).
REQ-007 SHALL have port LOAD_CLR  in  1  empty the program and return to IDLE.
REQ-008 SHALL have port START  in  1  begin playback from word 0.
REQ-009 SHALL have port EXT  in  1  processor external-data request (word consumed this step).
REQ-010 SHALL have port DONE  in  1  processor instruction-complete flag.
REQ-011 SHALL have port DATA_OUT  out  10  word to drive onto the processor input bus.
REQ-012 SHALL have port DATA_VALID  out  1  DATA_OUT holds a loaded word.
REQ-013 SHALL have port STEP  out  1  one-cycle pulse, one processor clock step.
REQ-014 SHALL have ports BUSY, HALT, ERR, FULL  out  1 each  status flags.
REQ-015 SHALL have port PC  out  log2(DEPTH)+1  read pointer.
REQ-016 SHALL have port COUNT  out  log2(DEPTH)+1  number of loaded words.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, GAP, FINISH and ERROR.
REQ-018 SHALL, in IDLE, accept a write when WR_EN=1 and FULL=0: mem[COUNT]<=WR_DATA, COUNT+1; FULL=(COUNT==DEPTH).
REQ-019 SHALL ignore WR_EN in any state other than IDLE, and whenever FULL=1.
REQ-020 SHALL, when LOAD_CLR=1 in any state, set COUNT=0 and PC=0, clear HALT and ERR, and go to IDLE on the next edge; LOAD_CLR has priority over WR_EN and START arriving in the same cycle.
REQ-021 SHALL, on START in IDLE or FINISH with COUNT>0, set PC=0 and go to ISSUE; START with COUNT=0 is ignored.
REQ-022 SHALL, in ISSUE, hold STEP=1 for exactly one cycle and sample EXT and DONE in that cycle, then go to GAP.
REQ-023 SHALL advance PC by 1 when the ISSUE cycle samples EXT=1 and PC<COUNT.
REQ-024 SHALL go to ERROR (underrun) instead of GAP when the ISSUE cycle samples EXT=1 and PC==COUNT.
REQ-025 SHALL stay in GAP for GAP_CYC cycles with STEP=0, then go to FINISH if DONE was sampled and PC==COUNT, otherwise go back to ISSUE.
REQ-026 SHALL drive DATA_OUT=mem[PC] and DATA_VALID=1 whenever PC<COUNT, and DATA_OUT=0, DATA_VALID=0 otherwise; the read path is combinational from the registered PC.
REQ-027 SHALL drive BUSY=1 in ISSUE and GAP; HALT=1 in FINISH; ERR=1 in ERROR.
REQ-028 SHALL hold the ERROR state until LOAD_CLR or reset; START is ignored in ERROR.

Reset
REQ-029 SHALL, on RSTb low, asynchronously force state=IDLE, PC=0, COUNT=0, STEP=0, BUSY=0, HALT=0, ERR=0, FULL=0, DATA_VALID=0 and DATA_OUT=0; memory contents are not reset.
REQ-030 SHALL, when reset is asserted mid-run, abandon any step in progress and issue no STEP after RSTb releases until a new START.

Configuration
REQ-031 SHALL, when the macro SEQ_STEP_WATCHDOG_EN is defined, count consecutive ISSUE cycles that sample DONE=0, reset that count on DONE=1 or START, and go to ERROR on the 4th such step, after its GAP.
REQ-032 SHALL, when SEQ_STEP_WATCHDOG_EN is undefined, contain no watchdog logic, so steps continue indefinitely without DONE.

Verification
REQ-033 The bench SHALL cover normal run: load 0x040 and 0x005, START, steps EXT=1,1,0 with DONE=1 on step 3 -> 3 STEP pulses, DATA_OUT 0x040 then 0x005, PC=2, HALT=1.
REQ-034 The bench SHALL cover underrun: load 1 word, START, EXT=1 on steps 1 and 2 -> ERR=1, PC=1, no 3rd STEP.
REQ-035 The bench SHALL cover overflow with DEPTH=16: write 17 words 0x000..0x010 -> COUNT=16, FULL=1, mem[15]=0x00F, 17th word dropped.
REQ-036 The bench SHALL cover LOAD_CLR=1 and WR_EN=1 in the same cycle with COUNT=3 -> COUNT=0, DATA_VALID=0.
REQ-037 The bench SHALL cover reset: RSTb low during GAP with PC=1 -> all outputs 0, IDLE, no STEP after release.
REQ-038 The bench SHALL cover the watchdog: macro defined, 4 words loaded, EXT=0 and DONE=0 for 4 steps -> ERR=1 after the 4th GAP; macro undefined -> a 5th STEP occurs and ERR=0.
